// File: rtl/flag_pulse_receiver_if.sv
// Signal bundle between the flag source side and the flag_pulse_receiver.
// The receiver uses the slave modport. The bench or the consumer uses the master modport.
interface flag_pulse_receiver_if #(
  parameter int unsigned COUNT_W = 8
);
  logic               flag_async_in;
  logic               overrun_clr;
  logic               flag_level_sync;
  logic               flag_pulse_out;
  logic               glitch_pulse_out;
  logic               busy;
  logic               overrun;
  logic [COUNT_W-1:0] flag_count;
  logic [COUNT_W-1:0] reject_count;

  modport slave (
    input  flag_async_in,
    input  overrun_clr,
    output flag_level_sync,
    output flag_pulse_out,
    output glitch_pulse_out,
    output busy,
    output overrun,
    output flag_count,
    output reject_count
  );

  modport master (
    output flag_async_in,
    output overrun_clr,
    input  flag_level_sync,
    input  flag_pulse_out,
    input  glitch_pulse_out,
    input  busy,
    input  overrun,
    input  flag_count,
    input  reject_count
  );
endinterface

// File: rtl/flag_pulse_receiver.sv
// Receiving end of the stretched-flag CDC. It synchronises the level and filters out glitches.
// It emits one pulse for each accepted flag and flags re-arrivals that come too soon.
module flag_pulse_receiver #(
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned MIN_HIGH    = 2,
  parameter int unsigned HOLDOFF     = 4,
  parameter int unsigned COUNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  flag_pulse_receiver_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StQualify, StWaitLow, StHoldoff} state_e;

  localparam logic [3:0] MinHigh4      = 4'(MIN_HIGH);
  localparam logic [3:0] Holdoff4      = 4'(HOLDOFF);
  localparam bit         AcceptOnFirst = (MIN_HIGH == 1);

  state_e               state;
  logic [SYNC_STAGES-1:0] syncChain;
  logic [3:0]           hcnt;
  logic                 flagPulse;
  logic                 glitchPulse;
  logic                 overrunFlag;
  logic [COUNT_W-1:0]   flagCount;
  logic [COUNT_W-1:0]   rejectCount;
  logic                 levelSync;

  assign levelSync = syncChain[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      syncChain <= '0;
    end else begin
      syncChain <= {syncChain[SYNC_STAGES-2:0], bus.flag_async_in};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= StIdle;
      hcnt        <= 4'd0;
      flagPulse   <= 1'b0;
      glitchPulse <= 1'b0;
      overrunFlag <= 1'b0;
      flagCount   <= '0;
      rejectCount <= '0;
    end else begin
      flagPulse   <= 1'b0;
      glitchPulse <= 1'b0;
      // A set later in this block overrides the clear.
      if (bus.overrun_clr) begin
        overrunFlag <= 1'b0;
      end
      case (state)
        StIdle: begin
          if (levelSync) begin
            hcnt <= 4'd1;
            if (AcceptOnFirst) begin
              state     <= StWaitLow;
              flagPulse <= 1'b1;
              flagCount <= flagCount + COUNT_W'(1);
            end else begin
              state <= StQualify;
            end
          end
        end
        StQualify: begin
          if (!levelSync) begin
            state       <= StIdle;
            glitchPulse <= 1'b1;
            rejectCount <= rejectCount + COUNT_W'(1);
          end else if (hcnt + 4'd1 == MinHigh4) begin
            state     <= StWaitLow;
            flagPulse <= 1'b1;
            flagCount <= flagCount + COUNT_W'(1);
          end else begin
            hcnt <= hcnt + 4'd1;
          end
        end
        StWaitLow: begin
          if (!levelSync) begin
            state <= StHoldoff;
            hcnt  <= 4'd1;
          end
        end
        StHoldoff: begin
          if (levelSync) begin
            // The flag that arrives too soon is still qualified and counted.
            overrunFlag <= 1'b1;
            hcnt        <= 4'd1;
            if (AcceptOnFirst) begin
              state     <= StWaitLow;
              flagPulse <= 1'b1;
              flagCount <= flagCount + COUNT_W'(1);
            end else begin
              state <= StQualify;
            end
          end else if (hcnt == Holdoff4) begin
            state <= StIdle;
          end else begin
            hcnt <= hcnt + 4'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.flag_level_sync  = levelSync;
  assign bus.flag_pulse_out   = flagPulse;
  assign bus.glitch_pulse_out = glitchPulse;
  assign bus.busy             = (state != StIdle);
  assign bus.overrun          = overrunFlag;
  assign bus.flag_count       = flagCount;
  assign bus.reject_count     = rejectCount;

endmodule

// File: tb/tb_flag_pulse_receiver.sv
// Self-checking bench for flag_pulse_receiver with its default parameters.
// A table of flag patterns drives the DUT. A queue scoreboard checks the cycle of every pulse.
module tb_flag_pulse_receiver;

  localparam int CountW  = 8;
  localparam int MinHigh = 2;
  localparam int Latency = 5;
  localparam int Tail    = 14;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;

  flag_pulse_receiver_if #(.COUNT_W(CountW)) bus ();

  flag_pulse_receiver #(
    .SYNC_STAGES(3),
    .MIN_HIGH   (2),
    .HOLDOFF    (4),
    .COUNT_W    (CountW)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int nVec  = 0;
  int nMiss = 0;
  int expFlagQ[$];
  int expGlitchQ[$];
  int expFlags   = 0;
  int expRejects = 0;
  logic prevFlag   = 1'b0;
  logic prevGlitch = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    nVec++;
    if (act != exp) begin
      nMiss++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard side: every pulse must match the cycle predicted when its rise was driven.
  always @(negedge clk) begin
    if (bus.flag_pulse_out) begin
      if (expFlagQ.size() == 0) check("unexpectedFlagPulse", 1, 0);
      else check("flagPulseCycle", cyc, expFlagQ.pop_front());
      check("flagPulseWidth", int'(prevFlag), 0);
      check("pulsesExclusive", int'(bus.glitch_pulse_out), 0);
    end
    if (bus.glitch_pulse_out) begin
      if (expGlitchQ.size() == 0) check("unexpectedGlitchPulse", 1, 0);
      else check("glitchPulseCycle", cyc, expGlitchQ.pop_front());
      check("glitchPulseWidth", int'(prevGlitch), 0);
    end
    prevFlag   <= bus.flag_pulse_out;
    prevGlitch <= bus.glitch_pulse_out;
  end

  // Drives the input high for high1 cycles, low for low cycles, and high for high2 cycles.
  // A low tail follows. overrun_clr is high only in cycle clrAt.
  task automatic runPattern(input int high1, input int low, input int high2, input int clrAt);
    int  total;
    int  len;
    bit  lvl;
    total = high1 + low + high2 + Tail;
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      bus.overrun_clr = (i == clrAt);
      lvl = (i < high1) || (i >= high1 + low && i < high1 + low + high2);
      if (lvl && !bus.flag_async_in) begin
        len = (i == 0) ? high1 : high2;
        if (len >= MinHigh) begin
          expFlagQ.push_back(cyc + Latency);
          expFlags++;
        end else begin
          expGlitchQ.push_back(cyc + Latency);
          expRejects++;
        end
      end
      bus.flag_async_in = lvl;
    end
    bus.overrun_clr = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    check({tag, ".flagCount"}, int'(bus.flag_count), expFlags % 256);
    check({tag, ".rejectCount"}, int'(bus.reject_count), expRejects % 256);
    check({tag, ".busy"}, int'(bus.busy), 0);
    check({tag, ".levelSync"}, int'(bus.flag_level_sync), 0);
    check({tag, ".pendingFlags"}, expFlagQ.size(), 0);
    check({tag, ".pendingGlitches"}, expGlitchQ.size(), 0);
  endtask

  typedef struct {
    int high1;
    int low;
    int high2;
    int expOverrun;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time %0t, expected it to finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{8,   0, 0, 0};  // single flag
    vecs[1] = '{1,   0, 0, 0};  // one-cycle glitch
    vecs[2] = '{2,   0, 0, 0};  // exactly MIN_HIGH
    vecs[3] = '{200, 0, 0, 0};  // long stretch
    vecs[4] = '{8,   2, 8, 1};  // overrun
    vecs[5] = '{8,   4, 8, 1};  // rise in last holdoff cycle
    vecs[6] = '{8,   5, 8, 0};  // rise just after holdoff
    vecs[7] = '{8,   2, 1, 1};  // glitch during holdoff

    reset_n           = 1'b0;
    bus.flag_async_in = 1'b0;
    bus.overrun_clr   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.flagPulse", int'(bus.flag_pulse_out), 0);
    check("rst.glitchPulse", int'(bus.glitch_pulse_out), 0);
    check("rst.busy", int'(bus.busy), 0);
    check("rst.overrun", int'(bus.overrun), 0);
    check("rst.levelSync", int'(bus.flag_level_sync), 0);
    check("rst.flagCount", int'(bus.flag_count), 0);
    check("rst.rejectCount", int'(bus.reject_count), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      runPattern(vecs[v].high1, vecs[v].low, vecs[v].high2, -1);
      checkIdle($sformatf("vec%0d", v));
      check($sformatf("vec%0d.overrun", v), int'(bus.overrun), vecs[v].expOverrun);
      @(negedge clk) bus.overrun_clr = 1'b1;
      @(negedge clk) bus.overrun_clr = 1'b0;
      check($sformatf("vec%0d.overrunCleared", v), int'(bus.overrun), 0);
    end

    // The clear lands on the same edge as the overrun set.
    runPattern(8, 2, 8, 13);
    checkIdle("setWins");
    check("setWins.overrun", int'(bus.overrun), 1);

    // Reset in QUALIFY with the input held high.
    @(negedge clk);
    bus.flag_async_in = 1'b1;
    expFlagQ.push_back(cyc + Latency);
    for (int i = 0; i < 10 && !bus.busy; i++) @(negedge clk);
    check("midReset.busyBefore", int'(bus.busy), 1);
    reset_n = 1'b0;
    #1;
    expFlagQ.delete();
    expFlags   = 0;
    expRejects = 0;
    check("midReset.flagPulse", int'(bus.flag_pulse_out), 0);
    check("midReset.busy", int'(bus.busy), 0);
    check("midReset.overrun", int'(bus.overrun), 0);
    check("midReset.levelSync", int'(bus.flag_level_sync), 0);
    check("midReset.flagCount", int'(bus.flag_count), 0);
    @(negedge clk);
    reset_n = 1'b1;
    expFlagQ.push_back(cyc + Latency);
    expFlags = 1;
    repeat (10) @(negedge clk);
    check("midReset.pending", expFlagQ.size(), 0);
    check("midReset.flagCountAfter", int'(bus.flag_count), 1);
    bus.flag_async_in = 1'b0;
    repeat (Tail) @(negedge clk);
    checkIdle("midReset.idle");

    // Counter wrap from a fresh reset.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n  = 1'b1;
    expFlags = 0;
    expRejects = 0;
    for (int n = 0; n < 256; n++) runPattern(2, 0, 0, -1);
    check("wrap.flagCount256", int'(bus.flag_count), 0);
    runPattern(2, 0, 0, -1);
    check("wrap.flagCount257", int'(bus.flag_count), 1);
    checkIdle("wrap");

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
